// File: rtl/kyber_pkg.sv
// Shared constants and types for the byte-stream coefficient decoder.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int ELL_MAX = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A width of zero or wider than the datapath cannot be decoded.
    function automatic logic d_is_legal(input logic [3:0] dw, input int ell_max);
        return (dw != 4'd0) && (int'(dw) <= ell_max);
    endfunction

endpackage

// File: rtl/decode_bitbuf.sv
// LSB-first bit accumulator: bytes are appended at position fill, coefficients
// are removed from the bottom. Exposes next-state values so the owner can register outputs.
module decode_bitbuf
    import kyber_pkg::*;
#(
    parameter int  ELL_MAX = kyber_pkg::ELL_MAX,
    localparam int AW      = ELL_MAX + 8,
    localparam int FW      = $clog2(ELL_MAX + 9)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    input  logic [3:0]    d_i,
    output logic [AW-1:0] acc_d_o,
    output logic [FW-1:0] fill_d_o
);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    // Next-state of accumulator and fill; push and pop are mutually exclusive upstream.
    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        if (clear_i) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (pop_i) begin
            acc_d  = acc_q >> d_i;
            fill_d = fill_q - FW'(d_i);
        end else if (push_i) begin
            acc_d  = acc_q | (AW'(data_i) << fill_q);
            fill_d = fill_q + FW'(4'd8);
        end else begin
            acc_d  = acc_q;
            fill_d = fill_q;
        end
    end

    // Accumulator and fill registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign acc_d_o  = acc_d;
    assign fill_d_o = fill_d;

endmodule

// File: rtl/byte_decode_stream.sv
// Decodes a byte stream into NUM_COEFFS d-bit coefficients (mod-Q reduced when d == 12).
// Optional DECODE_MODQ_CHECK_EN adds a sticky range_err output for raw values >= Q.
module byte_decode_stream
    import kyber_pkg::*;
#(
    parameter int ELL_MAX    = kyber_pkg::ELL_MAX,
    parameter int NUM_COEFFS = kyber_pkg::KYBER_N,
    parameter int Q          = kyber_pkg::KYBER_Q
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         d,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [ELL_MAX-1:0] out_coeff,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
`ifdef DECODE_MODQ_CHECK_EN
    ,
    output logic               range_err
`endif
);

    localparam int AW = ELL_MAX + 8;
    localparam int FW = $clog2(ELL_MAX + 9);
    localparam int CW = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;

    state_e             state_q, state_d;
    logic [3:0]         d_q, d_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ELL_MAX-1:0] out_coeff_q, out_coeff_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               start_ok_s;
    logic               cfg_bad_s;
    logic               push_s;
    logic               pop_s;
    logic               last_pop_s;
    logic               clear_s;
    logic [AW-1:0]      acc_nx_s;
    logic [FW-1:0]      fill_nx_s;
    logic [AW-1:0]      mask_s;
    logic [ELL_MAX-1:0] raw_s;
    logic               raw_over_q_s;

    assign start_ok_s = (state_q == ST_IDLE) && start && !abort && d_is_legal(d, ELL_MAX);
    assign cfg_bad_s  = (state_q == ST_IDLE) && start && !abort && !d_is_legal(d, ELL_MAX);
    assign push_s     = in_valid && in_ready_q;
    assign pop_s      = out_valid_q && out_ready;
    assign last_pop_s = (state_q == ST_RUN) && pop_s && (cnt_q == CW'(NUM_COEFFS - 1));
    assign clear_s    = abort || start_ok_s;

    decode_bitbuf #(
        .ELL_MAX (ELL_MAX)
    ) u_bitbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear_s),
        .push_i   (push_s),
        .data_i   (in_data),
        .pop_i    (pop_s),
        .d_i      (d_q),
        .acc_d_o  (acc_nx_s),
        .fill_d_o (fill_nx_s)
    );

    // FSM next-state, latched width and coefficient counter.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                    d_d     = d;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (last_pop_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (pop_s) begin
                    cnt_d   = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next state so every port comes straight from a flop.
    always_comb begin
        busy_d       = (state_d == ST_RUN);
        in_ready_d   = busy_d && (fill_nx_s < FW'(d_d));
        out_valid_d  = busy_d && (fill_nx_s >= FW'(d_d));
        mask_s       = (AW'(1'b1) << d_d) - AW'(1'b1);
        raw_s        = ELL_MAX'(acc_nx_s & mask_s);
        raw_over_q_s = (d_d == 4'd12) && (raw_s >= ELL_MAX'(Q));
        if (!out_valid_d) begin
            out_coeff_d = '0;
        end else if (raw_over_q_s) begin
            out_coeff_d = raw_s - ELL_MAX'(Q);
        end else begin
            out_coeff_d = raw_s;
        end
        done_d    = last_pop_s && !abort;
        cfg_err_d = cfg_bad_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            d_q         <= 4'd0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_coeff_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_coeff_q <= out_coeff_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_coeff = out_coeff_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

`ifdef DECODE_MODQ_CHECK_EN
    logic range_err_q, range_err_d;

    // Sticky flag for any out-of-range raw 12-bit value; a new polynomial clears it.
    always_comb begin
        range_err_d = range_err_q;
        if (start_ok_s) begin
            range_err_d = 1'b0;
        end else if (out_valid_d && raw_over_q_s) begin
            range_err_d = 1'b1;
        end else begin
            range_err_d = range_err_q;
        end
    end

    // Range flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_byte_decode_stream.sv
// Scoreboard bench for byte_decode_stream: expected coefficients come from a bit-level model.
module tb_byte_decode_stream;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [3:0]  d         = 4'd0;
    logic        abort     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = 8'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_coeff;
    logic        busy;
    logic        done;
    logic        cfg_err;
`ifdef DECODE_MODQ_CHECK_EN
    logic        range_err;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem [0:399];
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    byte_decode_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .d         (d),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_coeff (out_coeff),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
`ifdef DECODE_MODQ_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    function automatic logic [11:0] model_coeff(input int dd, input int idx);
        int v = 0;
        int bp;
        for (int b = 0; b < dd; b++) begin
            bp = idx * dd + b;
            v  = v | (int'(mem[bp / 8][bp % 8]) << b);
        end
        if (dd == 12 && v >= 3329) v = v - 3329;
        return 12'(v);
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 400; i++) mem[i] = 8'($urandom_range(255));
    endtask

    // Starts a decode of width dd, streams bytes, and scores coefficients until stop_at are taken.
    task automatic drive_poly(input int dd, input int rdy_pct, input int stop_at);
        int          coeff_idx = 0;
        int          cyc = 0;
        int          early_done = 0;
        int          overlap = 0;
        int          bytes_taken = 0;
        logic        held = 1'b0;
        logic [11:0] held_val = 12'd0;
        logic [11:0] e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(model_coeff(dd, i));
        @(negedge clk);
        start = 1'b1;
        d     = 4'(dd);
        @(negedge clk);
        start = 1'b0;
        d     = 4'd0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start d=%0d: got %b want 1", dd, busy);
        end
        while (coeff_idx < stop_at && cyc < 5000) begin
            if (done === 1'b1) early_done++;
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_coeff !== held_val) begin
                    n_bad++;
                    $display("FAIL hold_stable d=%0d: got v=%b c=%0d want v=1 c=%0d", dd, out_valid, out_coeff, held_val);
                end
            end
            in_valid  = (bytes_taken < 32 * dd + 2);
            in_data   = mem[bytes_taken];
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (in_ready === 1'b1 && out_valid === 1'b1) overlap++;
            held = 1'b0;
            if (in_valid && in_ready === 1'b1) bytes_taken++;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (out_coeff !== e) begin
                        n_bad++;
                        $display("FAIL coeff d=%0d idx=%0d: got %0d want %0d", dd, coeff_idx, out_coeff, e);
                    end
                    coeff_idx++;
                end else begin
                    held     = 1'b1;
                    held_val = out_coeff;
                end
            end
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (coeff_idx != stop_at) begin
            n_bad++;
            $display("FAIL timeout d=%0d: got %0d coefficients want %0d", dd, coeff_idx, stop_at);
        end
        n_cmp++;
        if (overlap != 0 || early_done != 0) begin
            n_bad++;
            $display("FAIL ready_valid_overlap_or_early_done d=%0d: got %0d/%0d want 0/0", dd, overlap, early_done);
        end
        if (stop_at == 256) begin
            n_cmp++;
            if (bytes_taken != 32 * dd) begin
                n_bad++;
                $display("FAIL byte_count d=%0d: got %0d want %0d", dd, bytes_taken, 32 * dd);
            end
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL done_pulse d=%0d: got done=%b busy=%b rdy=%b vld=%b want 1000", dd, done, busy, in_ready, out_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL done_single d=%0d: got %b want 0", dd, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy, done, cfg_err} !== 5'b0 || out_coeff !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got flags=%b coeff=%0d want 0/0", {in_ready, out_valid, busy, done, cfg_err}, out_coeff);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b rdy=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_d1();
        fill_mem();
        mem[0] = 8'hA5;
        drive_poly(1, 100, 256);
    endtask

    task automatic test_d12_modq();
        fill_mem();
        mem[0] = 8'hFF;
        mem[1] = 8'hFF;
        mem[2] = 8'hFF;
        drive_poly(12, 100, 256);
`ifdef DECODE_MODQ_CHECK_EN
        n_cmp++;
        if (range_err !== 1'b1) begin
            n_bad++;
            $display("FAIL range_err: got %b want 1", range_err);
        end
`endif
    endtask

    task automatic test_d12_small();
        fill_mem();
        mem[0] = 8'h01;
        mem[1] = 8'h20;
        mem[2] = 8'h00;
        drive_poly(12, 70, 256);
    endtask

    task automatic test_backpressure();
        fill_mem();
        drive_poly(11, 35, 256);
    endtask

    task automatic test_cfg_err();
        logic [3:0] bad_d [2];
        bad_d[0] = 4'd0;
        bad_d[1] = 4'd13;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1;
            d     = bad_d[k];
            @(negedge clk);
            start = 1'b0;
            d     = 4'd0;
            n_cmp++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL cfg_err_pulse d=%0d: got err=%b busy=%b rdy=%b want 1 0 0", bad_d[k], cfg_err, busy, in_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL cfg_err_clear d=%0d: got err=%b busy=%b want 0 0", bad_d[k], cfg_err, busy);
            end
        end
    endtask

    task automatic test_abort();
        fill_mem();
        drive_poly(12, 100, 3);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b1;
        d     = 4'd5;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        d     = 4'd0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b rdy=%b vld=%b done=%b want 0000", busy, in_ready, out_valid, done);
        end
        fill_mem();
        drive_poly(5, 80, 256);
    endtask

    task automatic test_reset_midrun();
        fill_mem();
        drive_poly(7, 100, 101);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, done, cfg_err} !== 5'b0 || out_coeff !== 12'd0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got flags=%b coeff=%0d want 0/0", {in_ready, out_valid, busy, done, cfg_err}, out_coeff);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_mem();
        mem[0] = 8'h3C;
        drive_poly(4, 100, 256);
    endtask

    initial begin
        test_reset();
        test_d1();
        test_d12_modq();
        test_d12_small();
        test_backpressure();
        test_cfg_err();
        test_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_decode_stream.md
BYTE_DECODE_STREAM -- requirements
Module: byte_decode_stream

Interface
REQ-001 SHALL have parameter ELL_MAX, default 12: largest supported coefficient width d.
REQ-002 SHALL have parameter NUM_COEFFS, default 256: coefficients per polynomial.
REQ-003 SHALL have parameter Q, default 3329: modulus applied when d == 12.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begins one polynomial decode.
REQ-007 SHALL have port d  in  4  coefficient width 1..ELL_MAX; sampled only on an accepted start.
REQ-008 SHALL have port abort  in  1  synchronous clear back to IDLE.
REQ-009 SHALL have port in_valid / in_data / in_ready  in/in/out  1/8/1  byte stream, LSB-first bit order.
REQ-010 SHALL have port out_valid / out_coeff / out_ready  out/out/in  1/ELL_MAX/1  coefficient stream, zero-extended above bit d-1.
REQ-011 SHALL have port busy  out  1  high in RUN.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last coefficient handshake.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse when start arrives with d == 0 or d > ELL_MAX.

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE->RUN on start with legal d; RUN->IDLE on final coefficient handshake or on abort.
REQ-015 SHALL ignore start while in RUN; start with illegal d SHALL stay in IDLE and pulse cfg_err the next cycle.
REQ-016 SHALL hold a bit accumulator of ELL_MAX+8 bits and a fill counter; an accepted byte is appended at bit position fill.
REQ-017 SHALL drive in_ready = RUN and fill < d; out_valid = RUN and fill >= d; the two SHALL never be high in the same cycle.
REQ-018 On a coefficient handshake, SHALL shift the accumulator right by d, reduce fill by d, and increment the coefficient counter.
REQ-019 SHALL present the coefficient registered: out_valid rises the cycle after the byte that completes it is accepted.
REQ-020 SHALL output acc[d-1:0] for d < 12, and for d == 12 SHALL output that value minus Q when it is >= Q (single conditional subtract).
REQ-021 SHALL hold out_coeff and out_valid stable while out_ready is low.
REQ-022 SHALL consume exactly 32*d bytes per polynomial and end with fill == 0; no byte SHALL be accepted after coefficient NUM_COEFFS-1 is formed.
REQ-023 Abort SHALL clear the accumulator, fill, and counter within one cycle without asserting done; abort has priority over start.

Reset
REQ-024 While rst_n is low, SHALL set state IDLE, accumulator 0, fill 0, counter 0, latched d 0, and all outputs 0 (in_ready, out_valid, busy, done, cfg_err, out_coeff).
REQ-025 Reset asserted mid-RUN SHALL discard the partial polynomial; the first start after release SHALL decode from coefficient 0.

Configuration
REQ-026 With DECODE_MODQ_CHECK_EN defined, SHALL add output range_err (1 bit), a sticky flag set when any raw d == 12 value is >= Q and cleared on the next accepted start or reset.
REQ-027 Without DECODE_MODQ_CHECK_EN, range_err SHALL be absent and the REQ-020 reduction behaviour SHALL be unchanged.

Structure
REQ-028 Package kyber_pkg SHALL hold KYBER_Q, KYBER_N, ELL_MAX, and the state enum type.
REQ-029 The accumulator and fill logic SHALL be the sub-module decode_bitbuf; the FSM, counter, and mod-Q logic SHALL stay in the top module.

Verification
REQ-030 Scenario: d = 1, first byte 0xA5 -> first 8 coefficients 1,0,1,0,0,1,0,1; 32 bytes total; done after coefficient 255.
REQ-031 Scenario: d = 12, bytes FF FF FF -> coefficients 766, 766; with DECODE_MODQ_CHECK_EN defined, range_err = 1.
REQ-032 Scenario: d = 12, bytes 01 20 00 -> coefficients 1, 2; 384 bytes consumed; done pulses exactly once.
REQ-033 Scenario: d = 11, out_ready randomly held low -> coefficients unchanged while held, none dropped or duplicated, zero-extended to ELL_MAX bits.
REQ-034 Scenario: start with d = 0 and with d = 13 -> cfg_err pulse, busy stays 0, in_ready stays 0.
REQ-035 Scenario: rst_n low after coefficient 100, then d = 4 start -> all outputs 0 during reset; coefficient 0 from low nibble of the first new byte.
